// File: rtl/dcache_sram_ctrl_if.sv
// dcache_sram_ctrl_if: two-requester (core=0, refill=1) request/response bus of the data-cache SRAM controller
interface dcache_sram_ctrl_if #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE    = 64
);
  localparam int NLANE = WIDTH / WORD_SIZE;
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_write;
  logic [LOG_NUM_ROWS-1:0] req_addr  [2];
  logic [WIDTH-1:0]        req_data  [2];
  logic [NLANE-1:0]        req_wmask [2];
  logic                    rsp_valid;
  logic                    rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    init_done;
  modport master (
    output req_valid, req_write, req_addr, req_data, req_wmask,
    input  req_ready, rsp_valid, rsp_id, rsp_data, init_done
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_wmask,
    output req_ready, rsp_valid, rsp_id, rsp_data, init_done
  );
endinterface

// File: rtl/dcache_sram_ctrl.sv
// dcache_sram_ctrl: clears every SRAM row after reset, then round-robin arbitrates core/refill reads and writes onto a 1-cycle-latency SRAM
module dcache_sram_ctrl #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  dcache_sram_ctrl_if.slave             bus,
  output logic [LOG_NUM_ROWS-1:0]       o_sram_read_addr,
  input  logic [WIDTH-1:0]              i_sram_read_data,
  output logic [LOG_NUM_ROWS-1:0]       o_sram_write_addr,
  output logic [WIDTH-1:0]              o_sram_write_data,
  output logic [WIDTH/WORD_SIZE-1:0]    o_sram_write_enable
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t                  r_state, w_state_nx;
  logic [LOG_NUM_ROWS-1:0] r_cnt, w_cnt_nx;
  logic                    r_rr, r_rsp_valid, r_rsp_id;
  logic                    w_run, w_gnt0, w_gnt1, w_gnt, w_id, w_rd;
  assign w_run  = r_state == S_RUN;
  // requester 0 wins unless requester 1 also wants the port and holds priority
  assign w_gnt0 = w_run & bus.req_valid[0] & (~bus.req_valid[1] | ~r_rr);
  assign w_gnt1 = w_run & bus.req_valid[1] & ~w_gnt0;
  assign w_gnt  = w_gnt0 | w_gnt1;
  assign w_id   = w_gnt1;
  assign w_rd   = w_gnt & ~bus.req_write[w_id];
  assign bus.req_ready = {w_gnt1, w_gnt0};
  assign bus.init_done = w_run;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_valid ? i_sram_read_data : '0;
  assign o_sram_read_addr = bus.req_addr[w_id];
  always_comb begin
    w_state_nx          = r_state;
    w_cnt_nx            = r_cnt;
    o_sram_write_addr   = bus.req_addr[w_id];
    o_sram_write_data   = bus.req_data[w_id];
    o_sram_write_enable = w_gnt & bus.req_write[w_id] ? bus.req_wmask[w_id] : '0;
    if (r_state == S_INIT) begin
      o_sram_write_addr   = r_cnt;
      o_sram_write_data   = '0;
      o_sram_write_enable = reset ? '0 : '1;
      w_cnt_nx            = r_cnt + 1'b1;
      w_state_nx          = &r_cnt ? S_RUN : S_INIT;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      if (w_gnt) r_rr <= ~w_id;
      r_rsp_valid <= w_rd;
      if (w_rd) r_rsp_id <= w_id;
    end
  end
endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// tb_dcache_sram_ctrl: directed stimulus with a per-cycle behavioural model of the init sweep, arbitration and row contents
module tb_dcache_sram_ctrl;
  localparam int W = 512, L = 9, WS = 64, NL = W / WS, NR = 1 << L;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  dcache_sram_ctrl_if #(.WIDTH(W), .LOG_NUM_ROWS(L), .WORD_SIZE(WS)) bus ();
  logic [L-1:0]  raddr, waddr;
  logic [W-1:0]  rdata, wdata;
  logic [NL-1:0] we;
  dcache_sram_ctrl #(.WIDTH(W), .LOG_NUM_ROWS(L), .WORD_SIZE(WS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .o_sram_read_addr(raddr), .i_sram_read_data(rdata),
    .o_sram_write_addr(waddr), .o_sram_write_data(wdata), .o_sram_write_enable(we)
  );
  logic [W-1:0] sram [NR];
  always @(posedge clk) begin
    rdata <= sram[raddr];
    for (int l = 0; l < NL; l++) if (we[l]) sram[waddr][l*WS+:WS] <= wdata[l*WS+:WS];
  end
  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  int           m_t;
  logic         m_rr, m_pv, m_pid, k, any;
  logic [W-1:0] m_pd;
  logic [L-1:0] a;
  logic [W-1:0] m_mem [NR];
  always @(negedge clk) begin
    if (reset) begin
      check("rst_rsp_valid", bus.rsp_valid, '0);
      check("rst_rsp_id", bus.rsp_id, '0);
      check("rst_rsp_data", bus.rsp_data, '0);
      check("rst_init_done", bus.init_done, '0);
      check("rst_ready", bus.req_ready, '0);
      check("rst_we", we, '0);
      m_t = 0; m_rr = 1'b0; m_pv = 1'b0;
    end else begin
      check("init_done", bus.init_done, m_t >= NR);
      check("rsp_valid", bus.rsp_valid, m_pv);
      if (m_pv) begin
        check("rsp_id", bus.rsp_id, m_pid);
        check("rsp_data", bus.rsp_data, m_pd);
      end
      m_pv = 1'b0;
      if (m_t < NR) begin
        check("init_ready", bus.req_ready, '0);
        check("init_we", we, {NL{1'b1}});
        check("init_waddr", waddr, m_t);
        check("init_wdata", wdata, '0);
        m_mem[m_t] = '0;
        m_t++;
      end else begin
        any = bus.req_valid[0] || bus.req_valid[1];
        k   = (bus.req_valid[0] && bus.req_valid[1]) ? m_rr : bus.req_valid[1];
        a   = bus.req_addr[k];
        check("ready", bus.req_ready, any ? (2'b01 << k) : 2'b00);
        if (any && bus.req_write[k]) begin
          check("wr_we", we, bus.req_wmask[k]);
          check("wr_waddr", waddr, a);
          check("wr_wdata", wdata, bus.req_data[k]);
          for (int l = 0; l < NL; l++)
            if (bus.req_wmask[k][l]) m_mem[a][l*WS+:WS] = bus.req_data[k][l*WS+:WS];
        end else begin
          check("idle_we", we, '0);
          if (any) begin
            check("rd_raddr", raddr, a);
            m_pv = 1'b1; m_pid = k; m_pd = m_mem[a];
          end
        end
        if (any) m_rr = !k;
      end
    end
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic drive(input int n, input logic wr, input logic [L-1:0] ad, input logic [W-1:0] d, input logic [NL-1:0] m);
    bus.req_valid[n] = 1'b1; bus.req_write[n] = wr; bus.req_addr[n] = ad;
    bus.req_data[n] = d; bus.req_wmask[n] = m;
  endtask
  localparam logic [W-1:0] D3 = {64{8'h33}}, D7 = {64{8'h77}};
  initial begin
    bus.req_valid = '0; bus.req_write = '0;
    for (int i = 0; i < 2; i++) begin
      bus.req_addr[i] = '0; bus.req_data[i] = '0; bus.req_wmask[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    #1 check("lit_row100", waddr, 100);
    reset = 1'b1;
    #1 check("lit_rst_we", we, '0);
    tick; reset = 1'b0;
    #1 check("lit_restart_addr", waddr, 0);
    check("lit_restart_we", we, 8'hFF);
    repeat (511) @(posedge clk);
    #2 check("lit_init_511", bus.init_done, 0);
    @(posedge clk);
    #2 check("lit_init_512", bus.init_done, 1);
    tick; drive(1, 1, 3, D3, 8'hFF);
    tick; drive(1, 1, 7, D7, 8'hFF);
    tick; bus.req_valid = '0;
    drive(0, 0, 3, '0, '0); drive(1, 0, 7, '0, '0);
    #1 check("lit_gnt_first", bus.req_ready, 2'b01);
    tick;
    #1 check("lit_gnt_second", bus.req_ready, 2'b10);
    check("lit_rsp0_id", bus.rsp_id, 0);
    check("lit_rsp0_data", bus.rsp_data, D3);
    tick; bus.req_valid = '0;
    #1 check("lit_rsp1_id", bus.rsp_id, 1);
    check("lit_rsp1_data", bus.rsp_data, D7);
    tick; drive(0, 1, 3, '1, '0);
    tick; drive(0, 0, 3, '0, '0);
    tick; bus.req_valid = '0;
    #1 check("lit_mask0", bus.rsp_data, D3);
    tick; drive(1, 1, 5, {64{8'hA5}}, 8'h01);
    tick; bus.req_valid = '0; drive(0, 0, 5, '0, '0);
    tick; bus.req_valid = '0;
    #1 check("lit_lane0", bus.rsp_data, {448'b0, 64'hA5A5A5A5A5A5A5A5});
    tick; drive(0, 0, 7, '0, '0); drive(1, 0, 3, '0, '0);
    #1 check("lit_rr_1_first", bus.req_ready, 2'b10);
    tick; tick; bus.req_valid = '0;
    tick; drive(0, 0, 3, '0, '0);
    tick; bus.req_valid = '0; reset = 1'b1;
    #1 check("lit_rst_drop", bus.rsp_valid, 0);
    tick; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick; check("lit_no_rsp", bus.rsp_valid, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dcache_sram_ctrl.md
DCACHE_SRAM_CTRL -- requirements
Module: dcache_sram_ctrl

Interface
REQ-001 Parameter WIDTH, default 512, SRAM row width in bits.
REQ-002 Parameter LOG_NUM_ROWS, default 9, log2 of SRAM row count; NUM_ROWS = 2**LOG_NUM_ROWS.
REQ-003 Parameter WORD_SIZE, default 64, bits per write-enable lane; NLANE = WIDTH/WORD_SIZE.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reqN_valid  input  1  requester N (N=0 core, N=1 refill) has a request.
REQ-007 reqN_ready  output  1  requester N request accepted this cycle.
REQ-008 reqN_write  input  1  1 = write, 0 = read.
REQ-009 reqN_addr  input  LOG_NUM_ROWS  target row.
REQ-010 reqN_data  input  WIDTH  write data.
REQ-011 reqN_wmask  input  NLANE  per-lane write enable; ignored for reads.
REQ-012 rsp_valid  output  1  read data valid.
REQ-013 rsp_id  output  1  requester owning the response.
REQ-014 rsp_data  output  WIDTH  read data.
REQ-015 init_done  output  1  row clear finished, requests accepted.
REQ-016 sram_readAddr  output  LOG_NUM_ROWS; sram_readData  input  WIDTH; sram_writeAddr  output  LOG_NUM_ROWS; sram_writeData  output  WIDTH; sram_writeEnable  output  NLANE -- SRAM port, registered 1-cycle read latency.

Function
REQ-017 FSM states INIT, RUN; reset enters INIT with row counter = 0.
REQ-018 INIT: each cycle drive sram_writeAddr = counter, sram_writeData = 0, sram_writeEnable = all ones; counter increments.
REQ-019 INIT -> RUN on the cycle after row NUM_ROWS-1 is written; init_done = 1 from that cycle until the next reset.
REQ-020 INIT: req0_ready = req1_ready = 0, rsp_valid = 0.
REQ-021 RUN: at most one request granted per cycle; reqN_ready is combinational, asserted only when reqN_valid and N granted.
REQ-022 Arbitration: round-robin; rr_ptr (reset 0) names the requester with priority on contention; single valid requester is granted regardless of rr_ptr.
REQ-023 After any grant to requester k, rr_ptr <= not k.
REQ-024 Granted write: sram_writeAddr = addr, sram_writeData = data, sram_writeEnable = wmask in the grant cycle; no response generated.
REQ-025 Granted write with wmask = 0 is accepted and is a no-op.
REQ-026 Granted read: sram_readAddr = addr in grant cycle N; rsp_valid = 1, rsp_id = k, rsp_data = sram_readData in cycle N+1.
REQ-027 sram_writeEnable = 0 in every cycle with no granted write or INIT write.
REQ-028 Read at N+1 of row written at N returns the new data; no forwarding logic is required.
REQ-029 Responses return in grant order; no response backpressure.
REQ-030 No request is ever dropped: an ungranted valid request stays pending with ready = 0.

Reset
REQ-031 Reset asserted: rsp_valid = 0, rsp_id = 0, rsp_data = 0, init_done = 0, req ready = 0, sram_writeEnable = 0, rr_ptr = 0, counter = 0, state = INIT.
REQ-032 Reset mid-INIT restarts the clear at row 0; reset mid-RUN discards any in-flight read response.
REQ-033 No output depends on SRAM contents during reset.

Verification
REQ-034 Deassert reset, no requests -> 512 cycles of writes rows 0..511 with data 0, mask 8'hFF; init_done rises on cycle 512.
REQ-035 After init, req0 and req1 both valid reads rows 3 and 7 for two cycles -> grant 0 then 1; rsp (id 0, row 3) then (id 1, row 7) on consecutive cycles.
REQ-036 req1 write row 5 data all 0xA5 mask 8'h01, next cycle req0 read row 5 -> rsp_data lane 0 = 64'hA5A5A5A5A5A5A5A5, lanes 1-7 = 0.
REQ-037 Reset asserted at INIT row 100 -> writes restart at row 0; init_done after 512 more cycles.
REQ-038 Read granted, reset asserted in next cycle before edge -> rsp_valid stays 0; no response after reset release.
